// File: rtl/deinterleaver_multirate_if.sv
// deinterleaver_multirate_if: beat input and symbol output bundle for the deinterleaver
interface deinterleaver_multirate_if #(
  parameter int SOFT_W    = 1,
  parameter int IN_W      = 6,
  parameter int MAX_NCBPS = 288
);
  logic                          en;
  logic [1:0]                    mode;
  logic [IN_W*SOFT_W-1:0]        in_data;
  logic [MAX_NCBPS*SOFT_W-1:0]   out_data;
  logic [1:0]                    out_mode;
  logic                          ready;
  modport master (output en, mode, in_data, input out_data, out_mode, ready);
  modport slave (input en, mode, in_data, output out_data, out_mode, ready);
endinterface

// File: rtl/deinterleaver_multirate.sv
// deinterleaver_multirate: 802.11a block deinterleaver, NBPSC bits per beat in, NCBPS bits per symbol out
module deinterleaver_multirate #(
  parameter int SOFT_W    = 1,
  parameter int IN_W      = 6,
  parameter int MAX_NCBPS = 288
) (
  input logic Clk,
  input logic Rst,
  deinterleaver_multirate_if.slave bus
);
  localparam int PW = $clog2(MAX_NCBPS);
  localparam int OW = MAX_NCBPS * SOFT_W;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [1:0]    mode_q, mode_d, cm, out_mode_q, out_mode_d;
  logic [3:0]    t_q, t_d;
  logic [1:0]    m_q, m_d, t3_q, t3_d;
  logic [OW-1:0] acc_q, acc_d, wr, out_q, out_d;
  logic          ready_q, ready_d, last;
  logic [2:0]    nb;
  // Beat n = 3t + m; floor(16j/NCBPS) collapses to t, so k = t + 16*(NBPSC*m + p)
  function automatic logic [PW-1:0] pos(input logic [1:0] md, input logic [2:0] nbv,
                                        input logic [2:0] b, input logic [3:0] t,
                                        input logic [1:0] t3, input logic [1:0] m);
    logic [2:0] base, r, v, p;
    logic [4:0] row, g;
    base = b >= 3'd3 ? 3'd3 : 3'd0;
    r = b - base;
    v = r + {1'b0, t3};
    p = md == 2'd3 ? base + (v >= 3'd3 ? v - 3'd3 : v) :
        md == 2'd2 ? {b[2:1], b[0] ^ t[0]} : b;
    row = m == 2'd0 ? 5'd0 : m == 2'd1 ? {2'd0, nbv} : {1'b0, nbv, 1'b0};
    g = row + {2'd0, p};
    return PW'({g, t});
  endfunction
  assign cm   = state_q == FILL ? mode_q : bus.mode;
  assign nb   = cm == 2'd0 ? 3'd1 : cm == 2'd1 ? 3'd2 : cm == 2'd2 ? 3'd4 : 3'd6;
  assign last = t_q == 4'd15 && m_q == 2'd2;
  always_comb begin
    wr = acc_q;
    for (int b = 0; b < IN_W; b++)
      if (3'(b) < nb)
        wr[int'(pos(cm, nb, 3'(b), t_q, t3_q, m_q)) * SOFT_W +: SOFT_W] = bus.in_data[b*SOFT_W +: SOFT_W];
    state_d    = bus.en ? (last ? IDLE : FILL) : state_q;
    mode_d     = bus.en ? cm : mode_q;
    m_d        = bus.en ? (m_q == 2'd2 ? 2'd0 : m_q + 2'd1) : m_q;
    t_d        = bus.en && m_q == 2'd2 ? t_q + 4'd1 : t_q;
    t3_d       = !(bus.en && m_q == 2'd2) ? t3_q : last || t3_q == 2'd2 ? 2'd0 : t3_q + 2'd1;
    acc_d      = bus.en ? (last ? '0 : wr) : acc_q;
    out_d      = bus.en && last ? wr : out_q;
    out_mode_d = bus.en && last ? cm : out_mode_q;
    ready_d    = bus.en && last;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      mode_q     <= 2'd0;
      t_q        <= 4'd0;
      m_q        <= 2'd0;
      t3_q       <= 2'd0;
      acc_q      <= '0;
      out_q      <= '0;
      out_mode_q <= 2'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      t_q        <= t_d;
      m_q        <= m_d;
      t3_q       <= t3_d;
      acc_q      <= acc_d;
      out_q      <= out_d;
      out_mode_q <= out_mode_d;
      ready_q    <= ready_d;
    end
  end
  assign bus.out_data = out_q;
  assign bus.out_mode = out_mode_q;
  assign bus.ready    = ready_q;
endmodule

// File: tb/tb_deinterleaver_multirate.sv
// tb_deinterleaver_multirate: scoreboard bench; expected symbols come from a forward 802.11a interleaver model
module tb_deinterleaver_multirate;
  localparam int SW = 3, IN_W = 6, MAXN = 288, OW = MAXN * SW, IW = IN_W * SW;
  logic Clk = 1'b0, Rst = 1'b1;
  always #5 Clk = ~Clk;
  deinterleaver_multirate_if #(.SOFT_W(SW), .IN_W(IN_W), .MAX_NCBPS(MAXN)) bus();
  deinterleaver_multirate #(.SOFT_W(SW), .IN_W(IN_W), .MAX_NCBPS(MAXN)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  typedef struct { logic [OW-1:0] d; logic [1:0] m; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0, errors = 0, ready_cnt = 0, cyc = 0, prev_ready = -1, fk;
  bit spacing_on = 1'b0;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk) if (bus.ready === 1'b1) begin
    ready_cnt++;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_ready at cycle %0d", cyc);
    end else begin
      mon_e = exp_q.pop_front();
      if (bus.out_data !== mon_e.d) begin
        fk = -1;
        for (int k = MAXN - 1; k >= 0; k--) if (bus.out_data[k*SW +: SW] !== mon_e.d[k*SW +: SW]) fk = k;
        errors++;
        $display("FAIL out_data first bad k=%0d got=%b exp=%b", fk, bus.out_data[fk*SW +: SW], mon_e.d[fk*SW +: SW]);
      end
      checks++;
      if (bus.out_mode !== mon_e.m) begin
        errors++;
        $display("FAIL out_mode got=%0d exp=%0d", bus.out_mode, mon_e.m);
      end
    end
    if (spacing_on && prev_ready >= 0) begin
      checks++;
      if (cyc - prev_ready != 48) begin
        errors++;
        $display("FAIL ready_spacing got=%0d exp=48", cyc - prev_ready);
      end
    end
    prev_ready = cyc;
  end
  function automatic int nbf(input logic [1:0] md);
    return md == 2'd0 ? 1 : md == 2'd1 ? 2 : md == 2'd2 ? 4 : 6;
  endfunction
  function automatic logic [OW-1:0] interleave(input logic [1:0] md, input logic [OW-1:0] d);
    int nb, n, s, i, j;
    logic [OW-1:0] tx;
    nb = nbf(md);
    n = 48 * nb;
    s = nb / 2 > 1 ? nb / 2 : 1;
    tx = '0;
    for (int k = 0; k < n; k++) begin
      i = (n / 16) * (k % 16) + k / 16;
      j = s * (i / s) + (i + n - (16 * i) / n) % s;
      tx[j*SW +: SW] = d[k*SW +: SW];
    end
    return tx;
  endfunction
  function automatic logic [OW-1:0] rnd_sym(input logic [1:0] md);
    logic [OW-1:0] v;
    v = '0;
    for (int k = 0; k < 48 * nbf(md) * SW; k++) v[k] = 1'($urandom_range(1));
    return v;
  endfunction
  task automatic beat(input logic e, input logic [1:0] md, input logic [IW-1:0] d);
    bus.en = e;
    bus.mode = md;
    bus.in_data = d;
    @(posedge Clk);
    #1;
  endtask
  task automatic send(input logic [1:0] md, input logic [OW-1:0] tx, input logic [OW-1:0] expd,
                      input bit gaps, input bit toggle, input int abort_at);
    int nb, r0;
    logic [IW-1:0] d;
    exp_t e;
    nb = nbf(md);
    r0 = ready_cnt;
    e.d = expd;
    e.m = md;
    if (abort_at < 0) exp_q.push_back(e);
    for (int n = 0; n < 48; n++) begin
      if (n == abort_at) begin
        Rst = 1'b1;
        beat(1'b1, md, IW'($urandom));
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got=%b exp=0", bus.ready); end
        checks++;
        if (bus.out_data !== '0) begin errors++; $display("FAIL rst_mid_out_data not cleared"); end
        Rst = 1'b0;
        return;
      end
      if (gaps && $urandom_range(2) == 0) repeat ($urandom_range(3, 1)) beat(1'b0, 2'($urandom), IW'($urandom));
      d = IW'($urandom);
      for (int b = 0; b < nb; b++) d[b*SW +: SW] = tx[(n*nb + b)*SW +: SW];
      beat(1'b1, (toggle && n > 0) ? 2'($urandom) : md, d);
      if (n == 0) r0 = ready_cnt;
    end
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL ready_latency got=%b exp=1", bus.ready); end
    checks++;
    if (ready_cnt != r0) begin errors++; $display("FAIL early_ready got=%0d exp=%0d", ready_cnt - r0, 0); end
  endtask
  task automatic test_reset();
    logic [OW-1:0] o;
    Rst = 1'b1;
    repeat (3) begin
      beat(1'b1, 2'($urandom), IW'($urandom));
      checks += 3;
      if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data not zero"); end
      if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
      if (bus.out_mode !== 2'd0) begin errors++; $display("FAIL reset_out_mode got=%0d exp=0", bus.out_mode); end
    end
    Rst = 1'b0;
    o = rnd_sym(2'd1);
    send(2'd1, interleave(2'd1, o), o, 1'b0, 1'b0, -1);
  endtask
  task automatic test_onehot();
    int cases[6][3] = '{'{1, 6, 1}, '{1, 1, 16}, '{0, 3, 1}, '{2, 12, 17}, '{2, 1, 16}, '{3, 18, 17}};
    logic [OW-1:0] tx, ex;
    logic [SW-1:0] v;
    for (int c = 0; c < 6; c++) begin
      v = SW'($urandom_range(7, 1));
      tx = '0;
      ex = '0;
      tx[cases[c][1]*SW +: SW] = v;
      ex[cases[c][2]*SW +: SW] = v;
      send(2'(cases[c][0]), tx, ex, 1'b0, 1'b0, -1);
    end
  endtask
  task automatic test_back_to_back();
    logic [1:0] modes[6] = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd3, 2'd2};
    logic [OW-1:0] o;
    prev_ready = -1;
    spacing_on = 1'b1;
    for (int s = 0; s < 6; s++) begin
      o = rnd_sym(modes[s]);
      send(modes[s], interleave(modes[s], o), o, 1'b0, 1'b0, -1);
    end
    beat(1'b0, 2'd0, '0);
    spacing_on = 1'b0;
  endtask
  task automatic test_gaps();
    logic [OW-1:0] o;
    o = rnd_sym(2'd1);
    send(2'd1, interleave(2'd1, o), o, 1'b0, 1'b0, -1);
    beat(1'b0, 2'd0, '0);
    send(2'd1, interleave(2'd1, o), o, 1'b1, 1'b1, -1);
    beat(1'b0, 2'd0, '0);
  endtask
  task automatic test_rst_mid();
    logic [OW-1:0] o;
    int r0;
    r0 = ready_cnt;
    o = rnd_sym(2'd1);
    send(2'd1, interleave(2'd1, o), o, 1'b0, 1'b0, 20);
    repeat (2) beat(1'b0, 2'd0, '0);
    checks++;
    if (ready_cnt != r0) begin errors++; $display("FAIL rst_mid_no_ready got=%0d exp=%0d", ready_cnt - r0, 0); end
    o = rnd_sym(2'd1);
    send(2'd1, interleave(2'd1, o), o, 1'b0, 1'b0, -1);
    beat(1'b0, 2'd0, '0);
  endtask
  initial begin
    bus.en = 1'b0;
    bus.mode = 2'd0;
    bus.in_data = '0;
    test_reset();
    test_onehot();
    test_back_to_back();
    test_gaps();
    test_rst_mid();
    repeat (3) beat(1'b0, 2'd0, '0);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL missing_ready got=%0d pending exp=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
